mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles an access waits for ram_memDataReady before it is aborted.
REQ-002 clk  in  1  single system clock; all logic SHALL sample on its rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 cpu_ReadMem, cpu_WriteMem  in  1 each  CPU read/write request levels, held until cpu_MemDataready.
REQ-005 cpu_Addressbus  in  16  CPU word address.
REQ-006 cpu_aluout  in  16  CPU write data.
REQ-007 cpu_Databus  out  16  CPU read data, valid while cpu_MemDataready=1.
REQ-008 cpu_MemDataready  out  1  one-cycle CPU completion pulse.
REQ-009 dma_ReadMem, dma_WriteMem, dma_Address, dma_DataIn, dma_DataOut, dma_MemDataready  same widths/meanings as REQ-004..008, for the DMA/IO-loader port.
REQ-010 ram_readMem, ram_wren  out  1 each  RAM strobes.
REQ-011 ram_address, ram_data  out  16 each  RAM address and write data.
REQ-012 ram_out  in  16  RAM read data; ram_memDataReady  in  1  RAM completion.
REQ-013 err_timeout  out  1  one-cycle pulse when an access is aborted; err_conflict  out  1  one-cycle pulse when a granted request has both read and write set.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-015 IDLE: if any requester asserts ReadMem or WriteMem, the FSM SHALL grant exactly one, latch its address, write data and direction, and enter ACCESS on the next edge.
REQ-016 Arbitration SHALL be round-robin: with both requesting, the port not granted last wins; after reset, CPU wins first.
REQ-017 ACCESS: ram_readMem or ram_wren (registered) SHALL be driven from the latched direction, with ram_address/ram_data held constant, until ram_memDataReady=1 is sampled.
REQ-018 On sampling ram_memDataReady=1, all strobes SHALL deassert next cycle, the FSM SHALL enter DONE, and ram_out SHALL be registered into the granted port's read-data output (reads only).
REQ-019 DONE: the granted port's MemDataready SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; the non-granted port's MemDataready SHALL stay 0.
REQ-020 Read data output SHALL hold its value until that port's next completed read.
REQ-021 Latency: request-to-pulse SHALL be 3 cycles when RAM answers in the first ACCESS cycle, plus one cycle per additional wait cycle.
REQ-022 An ACCESS cycle counter SHALL run; if it reaches TIMEOUT without ram_memDataReady, strobes SHALL drop, err_timeout SHALL pulse, and DONE SHALL proceed with read data unchanged.
REQ-023 Read+write both set at grant: treated as write, err_conflict pulses in the grant cycle.
REQ-024 Request inputs changing during ACCESS/DONE SHALL be ignored; a requester still asserting in IDLE after DONE SHALL be re-arbitrated normally (back-to-back accesses allowed).
REQ-025 ram_memDataReady asserted while in IDLE or DONE SHALL be ignored.

Reset
REQ-026 Reset SHALL force IDLE, all strobes/pulses/errors to 0, all data/address outputs to 0x0000, round-robin pointer to "DMA last", timeout counter to 0.
REQ-027 Reset asserted during ACCESS SHALL abort the access on the next edge with no completion pulse.

Structure
REQ-028 State encoding, port-select constants and default TIMEOUT SHALL reside in the shared package mem_arb_pkg.
REQ-029 One sub-module, rr_arbiter2 (two-requester round-robin grant with last-grant pointer), SHALL be instantiated; all else stays in mem_arbiter.

Verification
REQ-030 After reset, CPU read 0x0010, RAM ready in first ACCESS cycle with ram_out=0xBEEF -> cpu_MemDataready pulses 3 cycles after request, cpu_Databus=0xBEEF, DMA outputs unchanged.
REQ-031 CPU and DMA request simultaneously, held -> grants alternate CPU, DMA, CPU; each pulse exactly one cycle.
REQ-032 DMA write 0x1234 to 0x0020, RAM stalls 4 cycles -> ram_wren high 5 cycles, ram_address=0x0020, ram_data=0x1234 stable, dma_MemDataready 7 cycles after request.
REQ-033 CPU read with RAM never ready, TIMEOUT=15 -> strobes drop after 15 ACCESS cycles, err_timeout pulses once, cpu_Databus unchanged, FSM back in IDLE.
REQ-034 Reset asserted mid-ACCESS -> next cycle all outputs 0, no MemDataready pulse; following CPU request served normally.
REQ-035 CPU asserts ReadMem and WriteMem together -> err_conflict pulses at grant, ram_wren (not ram_readMem) asserted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/DMA memory arbiter:
// FSM states, port ids, default abort limit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_e;

    localparam int TIMEOUT_DEF = 15;

    typedef struct packed {
        port_e       port;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU, DMA and RAM bus bundle of the arbiter.
// master = arbiter side, slave = requesters/RAM side.
interface mem_arbiter_if;

    logic        cpu_ReadMem;
    logic        cpu_WriteMem;
    logic [15:0] cpu_Addressbus;
    logic [15:0] cpu_aluout;
    logic [15:0] cpu_Databus;
    logic        cpu_MemDataready;

    logic        dma_ReadMem;
    logic        dma_WriteMem;
    logic [15:0] dma_Address;
    logic [15:0] dma_DataIn;
    logic [15:0] dma_DataOut;
    logic        dma_MemDataready;

    logic        ram_readMem;
    logic        ram_wren;
    logic [15:0] ram_address;
    logic [15:0] ram_data;
    logic [15:0] ram_out;
    logic        ram_memDataReady;

    logic        err_timeout;
    logic        err_conflict;

    modport master (
        input  cpu_ReadMem, cpu_WriteMem,
        input  cpu_Addressbus, cpu_aluout,
        output cpu_Databus, cpu_MemDataready,
        input  dma_ReadMem, dma_WriteMem,
        input  dma_Address, dma_DataIn,
        output dma_DataOut, dma_MemDataready,
        output ram_readMem, ram_wren,
        output ram_address, ram_data,
        input  ram_out, ram_memDataReady,
        output err_timeout, err_conflict
    );

    modport slave (
        output cpu_ReadMem, cpu_WriteMem,
        output cpu_Addressbus, cpu_aluout,
        input  cpu_Databus, cpu_MemDataready,
        output dma_ReadMem, dma_WriteMem,
        output dma_Address, dma_DataIn,
        input  dma_DataOut, dma_MemDataready,
        input  ram_readMem, ram_wren,
        input  ram_address, ram_data,
        output ram_out, ram_memDataReady,
        input  err_timeout, err_conflict
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant; bit0 = CPU, bit1 = DMA.
// The pointer only moves when the caller accepts the grant.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       Reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    port_e last_q;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_q == PORT_DMA) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            last_q <= PORT_DMA;
        end else if (en && (gnt != 2'b00)) begin
            last_q <= gnt[1] ? PORT_DMA : PORT_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between CPU and DMA requesters,
// one access at a time, with an abort after TIMEOUT wait cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic           clk,
    input logic           Reset,
    mem_arbiter_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e    state_q;
    arb_state_e    state_d;
    grant_t        pick;
    port_e         acc_port;
    logic          acc_wr;
    logic [CW-1:0] cnt_q;
    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          grant_en;
    logic          timed_out;

    assign req = {bus.dma_ReadMem | bus.dma_WriteMem,
                  bus.cpu_ReadMem | bus.cpu_WriteMem};
    assign grant_en  = (state_q == IDLE) && (req != 2'b00);
    assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

    rr_arbiter2 u_rr (
        .clk   (clk),
        .Reset (Reset),
        .req   (req),
        .en    (grant_en),
        .gnt   (gnt)
    );

    always_comb begin
        pick.port  = PORT_CPU;
        pick.rd    = bus.cpu_ReadMem;
        pick.wr    = bus.cpu_WriteMem;
        pick.addr  = bus.cpu_Addressbus;
        pick.wdata = bus.cpu_aluout;
        if (gnt[1]) begin
            pick.port  = PORT_DMA;
            pick.rd    = bus.dma_ReadMem;
            pick.wr    = bus.dma_WriteMem;
            pick.addr  = bus.dma_Address;
            pick.wdata = bus.dma_DataIn;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_en) state_d = ACCESS;
            ACCESS:  if (bus.ram_memDataReady || timed_out)
                         state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            acc_port             <= PORT_CPU;
            acc_wr               <= 1'b0;
            cnt_q                <= '0;
            bus.ram_readMem      <= 1'b0;
            bus.ram_wren         <= 1'b0;
            bus.ram_address      <= '0;
            bus.ram_data         <= '0;
            bus.cpu_Databus      <= '0;
            bus.dma_DataOut      <= '0;
            bus.cpu_MemDataready <= 1'b0;
            bus.dma_MemDataready <= 1'b0;
            bus.err_timeout      <= 1'b0;
            bus.err_conflict     <= 1'b0;
        end else begin
            bus.cpu_MemDataready <= 1'b0;
            bus.dma_MemDataready <= 1'b0;
            bus.err_timeout      <= 1'b0;
            bus.err_conflict     <= 1'b0;
            unique case (state_q)
                IDLE: if (grant_en) begin
                    // read+write together resolves to a write
                    acc_port         <= pick.port;
                    acc_wr           <= pick.wr;
                    cnt_q            <= '0;
                    bus.ram_readMem  <= ~pick.wr;
                    bus.ram_wren     <= pick.wr;
                    bus.ram_address  <= pick.addr;
                    bus.ram_data     <= pick.wdata;
                    bus.err_conflict <= pick.rd & pick.wr;
                end
                ACCESS: if (bus.ram_memDataReady || timed_out) begin
                    bus.ram_readMem <= 1'b0;
                    bus.ram_wren    <= 1'b0;
                    bus.err_timeout <= ~bus.ram_memDataReady;
                    if (acc_port == PORT_CPU)
                        bus.cpu_MemDataready <= 1'b1;
                    else
                        bus.dma_MemDataready <= 1'b1;
                    if (bus.ram_memDataReady && !acc_wr) begin
                        if (acc_port == PORT_CPU)
                            bus.cpu_Databus <= bus.ram_out;
                        else
                            bus.dma_DataOut <= bus.ram_out;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a
// transaction-level model of grant order, latency and data.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        Reset;
    int          total = 0;
    int          bad = 0;
    logic [15:0] m_cpu_q;
    logic [15:0] m_dma_q;
    port_e       m_last;

    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input logic [1:0] cop,
                           input logic [1:0] dop);
        bus.cpu_ReadMem  = cop[0];
        bus.cpu_WriteMem = cop[1];
        bus.dma_ReadMem  = dop[0];
        bus.dma_WriteMem = dop[1];
    endtask

    task automatic scramble;
        bus.cpu_Addressbus = 16'($urandom);
        bus.cpu_aluout     = 16'($urandom);
        bus.dma_Address    = 16'($urandom);
        bus.dma_DataIn     = 16'($urandom);
        bus.ram_out        = 16'($urandom);
    endtask

    task automatic quiet(input string tag);
        chk({tag, ".rd"},  bus.ram_readMem, 0);
        chk({tag, ".wr"},  bus.ram_wren, 0);
        chk({tag, ".crdy"}, bus.cpu_MemDataready, 0);
        chk({tag, ".drdy"}, bus.dma_MemDataready, 0);
        chk({tag, ".tmo"}, bus.err_timeout, 0);
        chk({tag, ".cnf"}, bus.err_conflict, 0);
    endtask

    task automatic hold_data(input string tag);
        chk({tag, ".cpu_data"}, bus.cpu_Databus, m_cpu_q);
        chk({tag, ".dma_data"}, bus.dma_DataOut, m_dma_q);
    endtask

    task automatic reset_state(input string tag);
        quiet(tag);
        chk({tag, ".addr"}, bus.ram_address, 0);
        chk({tag, ".wdata"}, bus.ram_data, 0);
        chk({tag, ".cpu_data"}, bus.cpu_Databus, 0);
        chk({tag, ".dma_data"}, bus.dma_DataOut, 0);
    endtask

    task automatic model_reset;
        m_last  = PORT_DMA;
        m_cpu_q = '0;
        m_dma_q = '0;
    endtask

    // Called at a negedge with the arbiter idle; cycle 1 is the
    // request cycle, s is the number of RAM wait cycles.
    task automatic round(input logic [1:0] cop, input logic [1:0] dop,
                         input logic [15:0] ca, input logic [15:0] cd,
                         input logic [15:0] da, input logic [15:0] dd,
                         input int s, input logic [15:0] rdata);
        port_e       w;
        logic [1:0]  op;
        logic [15:0] addr;
        logic [15:0] wd;
        logic        tmo;
        int          a;
        if (cop != 0 && dop != 0)
            w = (m_last == PORT_DMA) ? PORT_CPU : PORT_DMA;
        else
            w = (cop != 0) ? PORT_CPU : PORT_DMA;
        m_last = w;
        op   = (w == PORT_CPU) ? cop : dop;
        addr = (w == PORT_CPU) ? ca : da;
        wd   = (w == PORT_CPU) ? cd : dd;
        tmo  = (s >= TO);
        a    = tmo ? TO : s + 1;
        set_req(cop, dop);
        bus.cpu_Addressbus   = ca;
        bus.cpu_aluout       = cd;
        bus.dma_Address      = da;
        bus.dma_DataIn       = dd;
        bus.ram_memDataReady = 1'($urandom);
        bus.ram_out          = 16'($urandom);
        for (int j = 2; j <= a + 3; j++) begin
            @(negedge clk);
            if (j <= a + 1) begin
                chk("acc.rd", bus.ram_readMem, !op[1]);
                chk("acc.wr", bus.ram_wren, op[1]);
                chk("acc.addr", bus.ram_address, addr);
                if (op[1]) chk("acc.wdata", bus.ram_data, wd);
                chk("acc.crdy", bus.cpu_MemDataready, 0);
                chk("acc.drdy", bus.dma_MemDataready, 0);
                chk("acc.cnf", bus.err_conflict,
                    (j == 2) && (op == 2'b11));
                chk("acc.tmo", bus.err_timeout, 0);
            end else if (j == a + 2) begin
                if (!op[1] && !tmo) begin
                    if (w == PORT_CPU) m_cpu_q = rdata;
                    else               m_dma_q = rdata;
                end
                chk("done.rd", bus.ram_readMem, 0);
                chk("done.wr", bus.ram_wren, 0);
                chk("done.crdy", bus.cpu_MemDataready,
                    w == PORT_CPU);
                chk("done.drdy", bus.dma_MemDataready,
                    w == PORT_DMA);
                chk("done.tmo", bus.err_timeout, tmo);
                chk("done.cnf", bus.err_conflict, 0);
                hold_data("done");
            end else begin
                quiet("idle");
                hold_data("idle");
            end
            if (j <= a + 1) begin
                scramble();
                set_req(2'($urandom), 2'($urandom));
                bus.ram_memDataReady = (j == s + 2);
                if (j == s + 2) bus.ram_out = rdata;
            end else begin
                set_req(2'b00, 2'b00);
                bus.ram_memDataReady = 1'($urandom);
                bus.ram_out = 16'($urandom);
            end
        end
    endtask

    // Both ports hold read requests with an always-ready RAM.
    task automatic rr_burst;
        port_e       w;
        logic [15:0] out_v;
        w     = m_last;
        out_v = '0;
        scramble();
        set_req(2'b01, 2'b01);
        bus.ram_memDataReady = 1'b1;
        for (int j = 2; j <= 10; j++) begin
            @(negedge clk);
            if (j % 3 == 0) begin
                w = (w == PORT_DMA) ? PORT_CPU : PORT_DMA;
                if (w == PORT_CPU) m_cpu_q = out_v;
                else               m_dma_q = out_v;
            end
            chk("rr.crdy", bus.cpu_MemDataready,
                (j % 3 == 0) && (w == PORT_CPU));
            chk("rr.drdy", bus.dma_MemDataready,
                (j % 3 == 0) && (w == PORT_DMA));
            chk("rr.rd", bus.ram_readMem, j % 3 == 2);
            hold_data("rr");
            out_v = 16'($urandom);
            bus.ram_out = out_v;
            if (j == 9) set_req(2'b00, 2'b00);
        end
        bus.ram_memDataReady = 1'b0;
        m_last = w;
    endtask

    task automatic apply_reset;
        Reset = 1'b1;
        set_req(2'b00, 2'b00);
        bus.ram_memDataReady = 1'b0;
        @(negedge clk);
        reset_state("rst");
        Reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic reset_mid;
        set_req(2'b01, 2'b00);
        bus.cpu_Addressbus   = 16'h0044;
        bus.ram_memDataReady = 1'b0;
        @(negedge clk);
        chk("mid.rd", bus.ram_readMem, 1);
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        reset_state("mid");
        Reset = 1'b0;
        set_req(2'b00, 2'b00);
        model_reset();
        @(negedge clk);
        quiet("mid.after");
    endtask

    initial begin
        Reset = 1'b1;
        set_req(2'b00, 2'b00);
        bus.cpu_Addressbus   = '0;
        bus.cpu_aluout       = '0;
        bus.dma_Address      = '0;
        bus.dma_DataIn       = '0;
        bus.ram_out          = '0;
        bus.ram_memDataReady = 1'b0;
        repeat (2) @(negedge clk);
        reset_state("por");
        Reset = 1'b0;
        model_reset();
        @(negedge clk);

        round(2'b01, 2'b00, 16'h0010, 16'h0, 16'h0, 16'h0,
              0, 16'hBEEF);
        apply_reset();
        rr_burst();
        round(2'b00, 2'b10, 16'h0, 16'h0, 16'h0020, 16'h1234,
              4, 16'h0);
        round(2'b01, 2'b00, 16'h0030, 16'h0, 16'h0, 16'h0,
              20, 16'hDEAD);
        round(2'b11, 2'b00, 16'h0040, 16'h5555, 16'h0, 16'h0,
              1, 16'h0);
        reset_mid();
        round(2'b01, 2'b00, 16'h0050, 16'h0, 16'h0, 16'h0,
              2, 16'hCAFE);

        for (int i = 0; i < 60; i++) begin
            logic [1:0] c;
            logic [1:0] d;
            c = 2'($urandom);
            d = 2'($urandom);
            if (c == 0 && d == 0) c = 2'b01;
            round(c, d, 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom),
                  int'($urandom_range(0, 19)), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
